// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and data memory: RAM sub-word accesses become aligned
// word reads (extract/extend) or word read-modify-writes; MMIO accesses pass straight through.
module mem_access_unit #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MMIO_BIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  mem_length,
  output logic        mem_sign,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  localparam logic [2:0] CntInit = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  // Holds store data on the way in, the merged RMW word, or the final load result.
  logic [31:0] data_q, data_d;
  logic        mmio_q, mmio_d;
  logic        err_q, err_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        req_mmio, req_err;
  logic [31:0] lane, lane_ext, merged;

  assign req_mmio = req_addr[MMIO_BIT];

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      3'b100, 3'b101:         req_err = req_we;
      default:                req_err = 1'b0;
    endcase
    if (!req_mmio) begin
      if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    end
  end

  always_comb begin
    lane = mem_dout >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  lane_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  lane_ext = {24'h0, lane[7:0]};
      3'b001:  lane_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  lane_ext = {16'h0, lane[15:0]};
      default: lane_ext = lane;
    endcase
    merged = mem_dout;
    if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else                    merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mmio_d  = mmio_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d   = req_we;
          f3_d   = req_funct3;
          addr_d = req_addr;
          mmio_d = req_mmio;
          err_d  = req_err;
          cnt_d  = CntInit;
          data_d = (req_we && !req_err) ? req_wdata : 32'h0;
          if (req_err)                                     state_d = StResp;
          else if (!req_we)                                state_d = StRd;
          else if (req_mmio || req_funct3[1:0] == 2'b10)   state_d = StWr;
          else                                             state_d = StRd;
        end
      end
      StRd: begin
        if (cnt_q == 3'd0) begin
          if (we_q) begin
            data_d  = merged;
            state_d = StWr;
          end else begin
            data_d  = mmio_q ? mem_dout : lane_ext;
            state_d = StResp;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_length = 2'd0;
    mem_sign   = 1'b0;
    mem_addr   = 32'h0;
    mem_din    = 32'h0;
    if (state_q == StRd || state_q == StWr) begin
      mem_addr   = mmio_q ? addr_q : {addr_q[31:2], 2'b00};
      mem_length = mmio_q ? f3_q[1:0] : 2'd2;
      mem_sign   = mmio_q & ~f3_q[2];
      mem_read   = (state_q == StRd);
      mem_write  = (state_q == StWr);
      mem_din    = (state_q == StWr) ? data_q : 32'h0;
    end
    if (state_q == StResp) begin
      resp_valid = 1'b1;
      resp_err   = err_q;
      resp_rdata = we_q ? 32'h0 : data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      mmio_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mmio_q  <= mmio_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized requests against a byte-level
// memory model, and a reset-during-RMW sequence.
module tb_mem_access_unit;

  localparam int unsigned RdLat = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_err, mem_sign, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
  logic [1:0]  mem_length;

  mem_access_unit #(.RD_LAT(RdLat), .MMIO_BIT(31)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_length(mem_length), .mem_sign(mem_sign), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Data memory stand-in: word RAM on bits [9:2], MMIO returns an address-derived pattern.
  logic [31:0] ram [256] = '{default: 32'h0};

  function automatic logic [31:0] mmio_val(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  assign mem_dout = !mem_read ? 32'h0 :
                    (mem_addr[31] ? mmio_val(mem_addr) : ram[mem_addr[9:2]]);

  always @(posedge clk) if (mem_write && !mem_addr[31]) ram[mem_addr[9:2]] <= mem_din;

  int          n_rd = 0, n_wr = 0, n_both = 0, n_resp = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic [1:0]  wr_len = 0;

  always @(negedge clk) begin
    if (mem_read) begin
      n_rd    <= n_rd + 1;
      rd_addr <= mem_addr;
    end
    if (mem_write) begin
      n_wr    <= n_wr + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_din;
      wr_len  <= mem_length;
    end
    if (mem_read && mem_write) n_both <= n_both + 1;
    if (resp_valid) n_resp <= n_resp + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: byte-granular little-endian memory and the decode/timing rules.
  logic [31:0] ref_ram [256] = '{default: 32'h0};

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int nr, output int nw, output logic [31:0] waddr,
                       output logic [31:0] wdat, output logic [1:0] wlen);
    logic        mmio;
    int          sz, off;
    logic [31:0] word, val;
    mmio = a[31];
    sz   = 1 << f3[1:0];
    off  = int'(a[1:0]);
    er   = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]) ||
           (!mmio && sz == 2 && a[0]) || (!mmio && sz == 4 && a[1:0] != 2'b00);
    rd = 0; lat = 1; nr = 0; nw = 0; waddr = 0; wdat = 0; wlen = 0;
    if (er) return;
    if (mmio) begin
      if (we) begin
        nw = 1; lat = 2; waddr = a; wdat = wd; wlen = f3[1:0];
      end else begin
        nr = RdLat; lat = RdLat + 1; rd = mmio_val(a);
      end
      return;
    end
    word = ref_ram[a[9:2]];
    if (!we) begin
      val = 0;
      for (int i = 0; i < sz; i++) val |= ((word >> (8 * (off + i))) & 32'hFF) << (8 * i);
      if (!f3[2] && sz < 4 && val[8 * sz - 1]) val = val - (32'd1 << (8 * sz));
      rd = val; nr = RdLat; lat = RdLat + 1;
    end else begin
      for (int i = 0; i < sz; i++)
        word = (word & ~(32'hFF << (8 * (off + i)))) |
               (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
      ref_ram[a[9:2]] = word;
      nw = 1; waddr = {a[31:2], 2'b00}; wdat = word; wlen = 2'd2;
      if (sz < 4) begin nr = RdLat; lat = RdLat + 2; end
      else lat = 2;
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int nr, output int nw);
    int r0, w0;
    @(negedge clk);
    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    r0 = n_rd; w0 = n_wr;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    lat = -1; rd = 32'hX; er = 1'bX;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i + 1; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
    nr = n_rd - r0; nw = n_wr - w0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [17];

  task automatic apply(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input bit use_exp,
                       input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] m_rd, m_wa, m_wd, d_rd;
    logic        m_er, d_er;
    logic [1:0]  m_wl;
    int          m_lat, m_nr, m_nw, d_lat, d_nr, d_nw;
    model(we, f3, a, wd, m_rd, m_er, m_lat, m_nr, m_nw, m_wa, m_wd, m_wl);
    run_req(we, f3, a, wd, d_rd, d_er, d_lat, d_nr, d_nw);
    if (use_exp) begin
      chk({name, "_rdata"}, d_rd, exp_rd);
      chk({name, "_err"}, {31'h0, d_er}, {31'h0, exp_er});
      chk({name, "_lat"}, 32'(d_lat), 32'(exp_lat));
    end else begin
      chk({name, "_rdata"}, d_rd, m_rd);
      chk({name, "_err"}, {31'h0, d_er}, {31'h0, m_er});
      chk({name, "_lat"}, 32'(d_lat), 32'(m_lat));
    end
    chk({name, "_reads"}, 32'(d_nr), 32'(m_nr));
    chk({name, "_writes"}, 32'(d_nw), 32'(m_nw));
    if (m_nr > 0) chk({name, "_rd_addr"}, rd_addr, a[31] ? a : {a[31:2], 2'b00});
    if (m_nw > 0) begin
      chk({name, "_wr_addr"}, wr_addr, m_wa);
      chk({name, "_wr_data"}, wr_data, m_wd);
      chk({name, "_wr_len"}, {30'h0, wr_len}, {30'h0, m_wl});
    end
  endtask

  initial begin
    logic [31:0] t_rd;
    logic        t_er;
    int          t_lat, t_nr, t_nw, w0, p0;

    vecs[0]  = '{"sw_init",  1, 3'b010, 32'h100, 32'h8899AABB, 32'h0,        0, 2};
    vecs[1]  = '{"lb_101",   0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 0, 2};
    vecs[2]  = '{"lbu_103",  0, 3'b100, 32'h103, 32'h0,        32'h00000088, 0, 2};
    vecs[3]  = '{"sb_102",   1, 3'b000, 32'h102, 32'h0000005C, 32'h0,        0, 3};
    vecs[4]  = '{"lw_after_sb", 0, 3'b010, 32'h100, 32'h0,     32'h885CAABB, 0, 2};
    vecs[5]  = '{"sh_102",   1, 3'b001, 32'h102, 32'h00001234, 32'h0,        0, 3};
    vecs[6]  = '{"lw_after_sh", 0, 3'b010, 32'h100, 32'h0,     32'h1234AABB, 0, 2};
    vecs[7]  = '{"sw_104",   1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0, 2};
    vecs[8]  = '{"lw_104",   0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 2};
    vecs[9]  = '{"lh_100",   0, 3'b001, 32'h100, 32'h0,        32'hFFFFAABB, 0, 2};
    vecs[10] = '{"lhu_102",  0, 3'b101, 32'h102, 32'h0,        32'h00001234, 0, 2};
    vecs[11] = '{"lw_mis",   0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 1};
    vecs[12] = '{"lh_mis",   0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 1};
    vecs[13] = '{"f3_011",   0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1};
    vecs[14] = '{"st_f3_100", 1, 3'b100, 32'h100, 32'h12345678, 32'h0,       1, 1};
    vecs[15] = '{"mmio_sh",  1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h0,   0, 2};
    vecs[16] = '{"mmio_lw",  0, 3'b010, 32'h80000020, 32'h0,   32'h40DE5A7A, 0, 2};

    #2 rst = 1'b0;
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++)
      apply(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b1,
            vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
    chk("mmio_sh_len", {30'h0, wr_len}, 32'h1);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? (32'h80000000 | 32'($urandom_range(0, 255)))
                                       : (32'h100 + 32'($urandom_range(0, 63)));
      apply("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
            1'b0, 32'h0, 1'b0, 0);
    end

    // Reset while an sb is in its read phase: nothing may be written or answered.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h101;
    req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w0 = n_wr; p0 = n_resp;
    @(negedge clk);
    chk("rst_mid_rd_active", {31'h0, mem_read}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_read_drop", {31'h0, mem_read}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_write", 32'(n_wr - w0), 32'h0);
    chk("rst_mid_no_resp", 32'(n_resp - p0), 32'h0);
    chk("rst_mid_ready_after", {31'h0, req_ready}, 32'h1);
    apply("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    apply("lw104_after_rst", 1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 32'h0, 1'b0, 0);

    chk("no_read_write_overlap", 32'(n_both), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
